// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a W-bit ADD/SUB/AND/OR through an external 4-bit
// combinational slice, one nibble per clock, least-significant nibble first.
// Optional build macro: ALU_SEQ_FLAGS_EN enables the rsp_zero / rsp_ovf flag
// logic; without it both flag ports are tied to 0.
module alu_nibble_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [4*NIBBLES-1:0]   req_a,
   input  logic [4*NIBBLES-1:0]   req_b,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [1:0]             alu_op,
   output logic                   alu_cin,
   input  logic [3:0]             alu_f,
   input  logic                   alu_cout,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [4*NIBBLES-1:0]   rsp_f,
   output logic                   rsp_cout,
   output logic                   rsp_zero,
   output logic                   rsp_ovf
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [1:0]      r_op;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;       // effective B: already inverted for SUB
   logic [W-1:0]    r_f;
   logic            r_cout;
   logic            r_req_ready;
   logic            r_rsp_valid;
   logic [3:0]      r_alu_a;
   logic [3:0]      r_alu_b;
   logic [1:0]      r_alu_op;
   logic            r_alu_cin;  // also holds the carry captured from the previous nibble

   logic            w_last;
   logic            w_arith;
   logic            w_hs;
   logic [W-1:0]    w_f_next;
   logic [3:0]      w_a_nxt;
   logic [3:0]      w_b_nxt;

   assign w_last  = (r_state == S_RUN) && (r_k == KW'(NIBBLES - 1));
   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_hs    = (r_state == S_IDLE) && req_valid && r_req_ready;

   // Result with the current slice nibble merged in at position k
   always_comb begin
      w_f_next = r_f;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (r_k == KW'(i)) w_f_next[i*4 +: 4] = alu_f;
      end
   end

   // Operand nibbles for the slice step that follows the current one
   always_comb begin
      w_a_nxt = 4'h0;
      w_b_nxt = 4'h0;
      for (int i = 1; i < int'(NIBBLES); i++) begin
         if (r_k == KW'(i - 1)) begin
            w_a_nxt = r_a[i*4 +: 4];
            w_b_nxt = r_b[i*4 +: 4];
         end
      end
   end

   // Sequencer: handshake, per-nibble slice drive/capture, response hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_op        <= OP_ADD;
         r_a         <= '0;
         r_b         <= '0;
         r_f         <= '0;
         r_cout      <= 1'b0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_alu_a     <= 4'h0;
         r_alu_b     <= 4'h0;
         r_alu_op    <= OP_ADD;
         r_alu_cin   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (w_hs) begin
                  r_req_ready <= 1'b0;
                  r_state     <= S_RUN;
                  r_k         <= '0;
                  r_op        <= req_op;
                  r_a         <= req_a;
                  r_b         <= (req_op == OP_SUB) ? ~req_b : req_b;
                  r_alu_a     <= req_a[3:0];
                  r_alu_b     <= (req_op == OP_SUB) ? ~req_b[3:0] : req_b[3:0];
                  r_alu_op    <= (req_op == OP_SUB) ? OP_ADD : req_op;
                  r_alu_cin   <= (req_op == OP_SUB);
               end
            end
            S_RUN: begin
               r_f <= w_f_next;
               if (w_last) begin
                  r_k         <= '0;
                  r_state     <= S_DONE;
                  r_rsp_valid <= 1'b1;
                  r_cout      <= w_arith & alu_cout;
                  r_alu_a     <= 4'h0;
                  r_alu_b     <= 4'h0;
                  r_alu_op    <= OP_ADD;
                  r_alu_cin   <= 1'b0;
               end else begin
                  r_k       <= r_k + KW'(1);
                  r_alu_a   <= w_a_nxt;
                  r_alu_b   <= w_b_nxt;
                  r_alu_cin <= alu_cout;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic r_zero;
   logic r_ovf;

   // Zero and signed-overflow flags, captured as the last nibble completes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_last) begin
         r_zero <= (w_f_next == '0);
         r_ovf  <= w_arith & (r_a[W-1] ^ r_b[W-1] ^ alu_f[3] ^ alu_cout);
      end
   end

   assign rsp_zero = r_zero;
   assign rsp_ovf  = r_ovf;
`else
   assign rsp_zero = 1'b0;
   assign rsp_ovf  = 1'b0;
`endif

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_f     = r_f;
   assign rsp_cout  = r_cout;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign alu_cin   = r_alu_cin;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: behavioural 4-bit slice attached, directed cases
// followed by random operations checked against a whole-word arithmetic model.
module tb_alu_nibble_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [1:0]    alu_op;
   logic          alu_cin;
   logic [3:0]    alu_f;
   logic          alu_cout;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_f;
   logic          rsp_cout;
   logic          rsp_zero;
   logic          rsp_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_cin   (alu_cin),
      .alu_f     (alu_f),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_f     (rsp_f),
      .rsp_cout  (rsp_cout),
      .rsp_zero  (rsp_zero),
      .rsp_ovf   (rsp_ovf)
   );

   // Behavioural 4-bit slice: add with carry, AND, OR
   logic [4:0] w_sum;
   assign w_sum = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
   assign {alu_cout, alu_f} = (alu_op == 2'b10) ? {1'b0, alu_a & alu_b} :
                              (alu_op == 2'b11) ? {1'b0, alu_a | alu_b} : w_sum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-word reference: result, carry, zero, signed overflow
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] f, output logic c, output logic z, output logic v);
      logic [W:0]   s;
      logic [W-1:0] nb;
      nb = ~b;
      case (op)
         2'b00:   s = (W+1)'(a) + (W+1)'(b);
         2'b01:   s = (W+1)'(a) + (W+1)'(nb) + (W+1)'(1);
         2'b10:   s = {1'b0, a & b};
         default: s = {1'b0, a | b};
      endcase
      f = s[W-1:0];
      c = (op == 2'b00 || op == 2'b01) ? s[W] : 1'b0;
      if (op == 2'b00)      v = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
      else if (op == 2'b01) v = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
      else                  v = 1'b0;
      z = (f == '0);
`ifndef ALU_SEQ_FLAGS_EN
      z = 1'b0;
      v = 1'b0;
`endif
   endtask

   // One full transaction; hold > 0 keeps rsp_ready low and offers a stray request
   task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
      logic [W-1:0] ef;
      logic         ec, ez, ev;
      logic [3:0]   eb0;
      int           lat;
      int           waited;
      model(op, a, b, ef, ec, ez, ev);
      eb0    = (op == 2'b01) ? ~b[3:0] : b[3:0];
      waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, ".hs_ready_low"}, 32'(req_ready), 32'(0));
      chk({tag, ".alu_a0"},       32'(alu_a),     32'(a[3:0]));
      chk({tag, ".alu_b0"},       32'(alu_b),     32'(eb0));
      chk({tag, ".alu_op0"},      32'(alu_op),    32'((op == 2'b01) ? 2'b00 : op));
      chk({tag, ".alu_cin0"},     32'(alu_cin),   32'(op == 2'b01));
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat),      32'(NIBBLES + 1));
      chk({tag, ".rsp_f"},   32'(rsp_f),    32'(ef));
      chk({tag, ".cout"},    32'(rsp_cout), 32'(ec));
      chk({tag, ".zero"},    32'(rsp_zero), 32'(ez));
      chk({tag, ".ovf"},     32'(rsp_ovf),  32'(ev));
      chk({tag, ".alu_idle"}, 32'({alu_a, alu_b, alu_op, alu_cin}), 32'(0));
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_op    = 2'b11;
         req_a     = ~a;
         req_b     = ~b;
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'(1));
         chk({tag, ".hold_f"},     32'({rsp_f, rsp_cout, rsp_zero, rsp_ovf}),
                                   32'({ef, ec, ez, ev}));
         chk({tag, ".hold_ready"}, 32'(req_ready), 32'(0));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".release_valid"}, 32'(rsp_valid), 32'(0));
      chk({tag, ".release_ready"}, 32'(req_ready), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.req_ready", 32'(req_ready), 32'(0));
      chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst.rsp",       32'({rsp_f, rsp_cout, rsp_zero, rsp_ovf}), 32'(0));
      chk("rst.alu",       32'({alu_a, alu_b, alu_op, alu_cin}), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.req_ready", 32'(req_ready), 32'(1));

      // Directed cases
      do_op("add_carry", 2'b00, 16'h00FF, 16'h0001, 0);
      do_op("sub_eq",    2'b01, 16'h0005, 16'h0005, 0);
      do_op("add_ovf",   2'b00, 16'h7FFF, 16'h0001, 0);
      do_op("and",       2'b10, 16'hF0F0, 16'h0FF0, 0);
      do_op("sub_3",     2'b01, 16'h0003, 16'h0003, 0);
      do_op("sub_ovf",   2'b01, 16'h8000, 16'h0001, 0);
      do_op("backpress", 2'b00, 16'h1234, 16'h0F0F, 10);

      // Reset while the third nibble is on the slice
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 16'h1111;
      req_b     = 16'h2222;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort.k2_alu_a", 32'(alu_a), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.rsp_valid", 32'(rsp_valid), 32'(0));
      chk("abort.alu",       32'({alu_a, alu_b, alu_op, alu_cin}), 32'(0));
      chk("abort.req_ready", 32'(req_ready), 32'(0));
      @(negedge clk);
      chk("abort.idle_ready", 32'(req_ready), 32'(1));
      chk("abort.no_rsp",     32'(rsp_valid), 32'(0));
      do_op("or_after_rst", 2'b11, 16'h1234, 16'h4321, 0);

      // Random operations
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (n % 8 == 0) rb = ra;
         do_op("rand", rop, ra, rb, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
